// File: rtl/frame_tx_pkg.sv
// rtl/frame_tx_pkg.sv - host protocol framing constants and crc16 byte update
package frame_tx_pkg;

  localparam logic [7:0]  FRAME_SYNC     = 8'h7e;
  localparam int          FRAME_OVERHEAD = 5;
  localparam int          MAX_FRAME      = 64;
  localparam logic [3:0]  SEQ_HI         = 4'h1;
  localparam logic [15:0] CRC16_INIT     = 16'hffff;

  // One byte of the host crc16; shared by the transmit and receive framers.
  function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] b);
    logic [7:0] d;
    d = b ^ crc[7:0];
    d = d ^ (d << 4);
    return {d, crc[15:8]} ^ {12'h000, d[7:4]} ^ {5'b00000, d, 3'b000};
  endfunction

endpackage

// File: rtl/frame_crc16.sv
// rtl/frame_crc16.sv - registered crc16 accumulator with init and byte update
module frame_crc16
  import frame_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        update,
  input  logic [7:0]  data,
  output logic [15:0] value
);

  // Restart on init, otherwise fold in one byte per update strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= CRC16_INIT;
    end else if (init) begin
      value <= CRC16_INIT;
    end else if (update) begin
      value <= crc16_update(value, data);
    end
  end

endmodule

// File: rtl/frame_tx.sv
// rtl/frame_tx.sv - wraps responses into len/seq/payload/crc16/sync frames for the UART
module frame_tx
  import frame_tx_pkg::*;
#(
  parameter int         LEN_BITS    = 8,
  parameter int         MAX_PAYLOAD = MAX_FRAME - FRAME_OVERHEAD,
  parameter logic [7:0] SYNC_BYTE   = FRAME_SYNC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LEN_BITS-1:0] len_fifo_data,
  input  logic                len_fifo_empty,
  output logic                len_fifo_rd_en,
  input  logic [7:0]          ring_data,
  input  logic                ring_empty,
  output logic                ring_rd_en,
  input  logic [3:0]          seq,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                frame_done,
  output logic                err_overlong
);

  // The *_POP states are the cycle the registered rd_en pulse is high; the
  // popped data is valid in the following *_WAIT state.
  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_POP,
    S_LEN_WAIT,
    S_HDR_LEN,
    S_HDR_SEQ,
    S_PAY_RD,
    S_PAY_POP,
    S_PAY_WAIT,
    S_PAY_SEND,
    S_CRC_HI,
    S_CRC_LO,
    S_SYNC,
    S_DISCARD
  } state_t;

  state_t              state;
  logic [LEN_BITS-1:0] remaining;
  logic [3:0]          seq_q;
  logic [7:0]          byte_q;
  logic                crc_init;
  logic                crc_update;
  logic [15:0]         crc_value;

  // crc covers only the header and payload bytes, folded in as they transfer.
  assign crc_init   = (state == S_LEN_WAIT);
  assign crc_update = tx_valid && tx_ready &&
                      ((state == S_HDR_LEN) || (state == S_HDR_SEQ) || (state == S_PAY_SEND));

  frame_crc16 u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (crc_init),
    .update (crc_update),
    .data   (byte_q),
    .value  (crc_value)
  );

  // crc bytes come straight from the accumulator, which is frozen in those states.
  always_comb begin
    tx_data = byte_q;
    if (state == S_CRC_HI) begin
      tx_data = crc_value[15:8];
    end else if (state == S_CRC_LO) begin
      tx_data = crc_value[7:0];
    end
  end

  // Frame sequencer: pops, header/payload/trailer emission and overlong discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      remaining      <= '0;
      seq_q          <= 4'h0;
      byte_q         <= 8'h00;
      tx_valid       <= 1'b0;
      len_fifo_rd_en <= 1'b0;
      ring_rd_en     <= 1'b0;
      frame_done     <= 1'b0;
      err_overlong   <= 1'b0;
    end else begin
      len_fifo_rd_en <= 1'b0;
      ring_rd_en     <= 1'b0;
      frame_done     <= 1'b0;
      err_overlong   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!len_fifo_empty) begin
            len_fifo_rd_en <= 1'b1;
            state          <= S_LEN_POP;
          end
        end
        S_LEN_POP: begin
          state <= S_LEN_WAIT;
        end
        S_LEN_WAIT: begin
          remaining <= len_fifo_data;
          seq_q     <= seq;
          if (int'(len_fifo_data) > MAX_PAYLOAD) begin
            err_overlong <= 1'b1;
            state        <= S_DISCARD;
          end else begin
            byte_q   <= 8'(len_fifo_data) + 8'(FRAME_OVERHEAD);
            tx_valid <= 1'b1;
            state    <= S_HDR_LEN;
          end
        end
        S_HDR_LEN: begin
          if (tx_ready) begin
            byte_q <= {SEQ_HI, seq_q};
            state  <= S_HDR_SEQ;
          end
        end
        S_HDR_SEQ: begin
          if (tx_ready) begin
            if (remaining == '0) begin
              state <= S_CRC_HI;
            end else begin
              tx_valid <= 1'b0;
              state    <= S_PAY_RD;
            end
          end
        end
        S_PAY_RD: begin
          if (!ring_empty) begin
            ring_rd_en <= 1'b1;
            state      <= S_PAY_POP;
          end
        end
        S_PAY_POP: begin
          state <= S_PAY_WAIT;
        end
        S_PAY_WAIT: begin
          byte_q   <= ring_data;
          tx_valid <= 1'b1;
          state    <= S_PAY_SEND;
        end
        S_PAY_SEND: begin
          if (tx_ready) begin
            remaining <= remaining - 1'b1;
            if (remaining == LEN_BITS'(1)) begin
              state <= S_CRC_HI;
            end else begin
              tx_valid <= 1'b0;
              state    <= S_PAY_RD;
            end
          end
        end
        S_CRC_HI: begin
          if (tx_ready) begin
            state <= S_CRC_LO;
          end
        end
        S_CRC_LO: begin
          if (tx_ready) begin
            byte_q <= SYNC_BYTE;
            state  <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (tx_ready) begin
            tx_valid   <= 1'b0;
            frame_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_DISCARD: begin
          // Pulse every other cycle at most so pops are never back to back.
          if (remaining == '0) begin
            state <= S_IDLE;
          end else if (!ring_rd_en && !ring_empty) begin
            ring_rd_en <= 1'b1;
            remaining  <= remaining - 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// tb/tb_frame_tx.sv - scoreboard bench for frame_tx
module tb_frame_tx;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] len_fifo_data;
  logic       len_fifo_empty;
  logic       len_fifo_rd_en;
  logic [7:0] ring_data;
  logic       ring_empty;
  logic       ring_rd_en;
  logic [3:0] seq;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       frame_done;
  logic       err_overlong;

  int checks = 0;
  int errors = 0;

  exp_t       exp_q[$];
  logic [3:0] seq_q[$];
  logic [7:0] pay [0:63];

  logic [7:0] len_mem [0:31];
  int         len_wr = 0;
  int         len_rd = 0;
  logic [7:0] ring_mem [0:255];
  int         ring_wr = 0;
  int         ring_rd = 0;

  bit   rand_mode   = 0;
  bit   ready_fixed = 1;
  bit   pending_last = 0;
  int   overlong_cnt = 0;
  int   pop_viol = 0;

  frame_tx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .len_fifo_data  (len_fifo_data),
    .len_fifo_empty (len_fifo_empty),
    .len_fifo_rd_en (len_fifo_rd_en),
    .ring_data      (ring_data),
    .ring_empty     (ring_empty),
    .ring_rd_en     (ring_rd_en),
    .seq            (seq),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .frame_done     (frame_done),
    .err_overlong   (err_overlong)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign len_fifo_empty = (len_wr == len_rd);
  assign ring_empty     = (ring_wr == ring_rd);

  // Source FIFO models: data valid the cycle after the pop pulse.
  always @(posedge clk) begin
    if (len_fifo_rd_en) begin
      len_fifo_data <= len_mem[len_rd];
      len_rd        <= len_rd + 1;
    end
    if (ring_rd_en) begin
      ring_data <= ring_mem[ring_rd];
      ring_rd   <= ring_rd + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int crc_model(input int c, input int b);
    int d;
    d = (b ^ c) & 255;
    d = (d ^ (d << 4)) & 255;
    return (((d << 8) | (c >> 8)) ^ (d >> 4) ^ (d << 3)) & 16'hffff;
  endfunction

  task automatic push_exp(input int b, input bit last);
    exp_t e;
    e.b    = 8'(b);
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic push_len(input int len, input int s);
    seq_q.push_back(4'(s));
    len_mem[len_wr] = 8'(len);
    len_wr++;
  endtask

  task automatic ring_push(input int b);
    ring_mem[ring_wr] = 8'(b);
    ring_wr++;
  endtask

  // Expected frame from the bench model; payload taken from pay[].
  task automatic push_frame(input int len, input int s);
    int c;
    int b;
    c = 16'hffff;
    b = len + 5;
    push_exp(b, 0);
    c = crc_model(c, b);
    b = 8'h10 | s;
    push_exp(b, 0);
    c = crc_model(c, b);
    for (int i = 0; i < len; i++) begin
      push_exp(pay[i], 0);
      c = crc_model(c, pay[i]);
    end
    push_exp(c >> 8, 0);
    push_exp(c & 255, 0);
    push_exp(8'h7e, 1);
    push_len(len, s);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pending_last) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, (n < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  // tx_ready driver, updated just after each active edge.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Output monitor: scoreboard compare, stability, end-of-frame and pop rules.
  initial begin
    bit         prev_valid;
    bit         prev_ready;
    logic [7:0] prev_data;
    bit         prev_ring_en;
    bit         prev_len_en;
    exp_t       e;
    prev_valid   = 0;
    prev_ready   = 0;
    prev_data    = 8'h00;
    prev_ring_en = 0;
    prev_len_en  = 0;
    seq          = 4'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid   = 0;
        prev_ring_en = 0;
        prev_len_en  = 0;
        pending_last = 0;
      end else begin
        if (pending_last) begin
          check_eq("valid_after_sync", tx_valid, 0);
          check_eq("frame_done", frame_done, 1);
          pending_last = 0;
        end else if (frame_done) begin
          check_eq("spurious_frame_done", frame_done, 0);
        end
        if (prev_valid && !prev_ready) begin
          check_eq("hold_valid", tx_valid, 1);
          check_eq("hold_data", tx_data, prev_data);
        end
        if (err_overlong) overlong_cnt++;
        if (ring_rd_en && (prev_ring_en || ring_empty)) pop_viol++;
        if (len_fifo_rd_en && (prev_len_en || len_fifo_empty)) pop_viol++;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_byte", tx_data, 32'hffffffff);
          end else begin
            e = exp_q.pop_front();
            check_eq("tx_byte", tx_data, e.b);
            pending_last = e.last;
          end
        end
        if (len_fifo_rd_en) begin
          if (seq_q.size() != 0) seq = seq_q.pop_front();
        end else if (tx_valid) begin
          seq = 4'($urandom_range(0, 15));
        end
        prev_valid   = tx_valid;
        prev_ready   = tx_ready;
        prev_data    = tx_data;
        prev_ring_en = ring_rd_en;
        prev_len_en  = len_fifo_rd_en;
      end
    end
  end

  initial begin
    int base;
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_len_rd_en", len_fifo_rd_en, 0);
    check_eq("rst_ring_rd_en", ring_rd_en, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_err_overlong", err_overlong, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // L=0, seq=0: fixed reference bytes
    push_exp(8'h05, 0);
    push_exp(8'h10, 0);
    push_exp(8'h9e, 0);
    push_exp(8'h81, 0);
    push_exp(8'h7e, 1);
    push_len(0, 0);
    drain("t1_timeout", 100);

    // L=1, ring {00}, seq=3: exactly one ring pop
    base   = ring_rd;
    pay[0] = 8'h00;
    ring_push(8'h00);
    push_frame(1, 3);
    drain("t2_timeout", 100);
    check_eq("t2_ring_pops", ring_rd - base, 1);

    // L=3 with ring bytes arriving 10 cycles apart
    base   = ring_rd;
    pay[0] = 8'ha5;
    pay[1] = 8'h3c;
    pay[2] = 8'hff;
    push_frame(3, 6);
    for (int i = 0; i < 3; i++) begin
      repeat (10) @(negedge clk);
      check_eq("t3_stall_valid", tx_valid, 0);
      ring_push(pay[i]);
    end
    drain("t3_timeout", 200);
    check_eq("t3_ring_pops", ring_rd - base, 3);

    // Back-to-back frames (2 then 5) with random tx_ready
    rand_mode = 1;
    pay[0] = 8'h11;
    pay[1] = 8'h22;
    ring_push(8'h11);
    ring_push(8'h22);
    push_frame(2, 5);
    for (int i = 0; i < 5; i++) begin
      pay[i] = 8'(8'h40 + 7 * i);
      ring_push(pay[i]);
    end
    push_frame(5, 9);
    drain("t4_timeout", 1000);
    rand_mode = 0;

    // Overlong length: discard 60 ring bytes, then an L=0 frame
    base         = ring_rd;
    overlong_cnt = 0;
    for (int i = 0; i < 60; i++) ring_push(i);
    push_len(60, 4);
    push_frame(0, 12);
    drain("t5_timeout", 1000);
    check_eq("t5_overlong_pulses", overlong_cnt, 1);
    check_eq("t5_ring_pops", ring_rd - base, 60);

    // Reset while a payload byte is waiting for tx_ready
    for (int i = 0; i < 4; i++) begin
      pay[i] = 8'(8'h80 + i);
      ring_push(pay[i]);
    end
    push_frame(4, 2);
    n = 0;
    while (!ring_rd_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_pop_seen", (n < 100), 1);
    ready_fixed = 0;
    n = 0;
    while (!tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_payload_valid", tx_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_tx_valid", tx_valid, 0);
    check_eq("t6_rst_ring_rd_en", ring_rd_en, 0);
    check_eq("t6_rst_len_rd_en", len_fifo_rd_en, 0);
    check_eq("t6_rst_frame_done", frame_done, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_eq("t6_held_tx_valid", tx_valid, 0);
    ready_fixed = 1;
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push_frame(0, 10);
    drain("t6_timeout", 100);

    check_eq("pop_rule_violations", pop_viol, 0);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
